// File: rtl/lbdr_output_port_selector_pkg.sv
// rtl/lbdr_output_port_selector_pkg.sv - shared port indices, sizes and FSM encoding
// for the LBDR output-port selection stage.
package lbdr_output_port_selector_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  localparam int NUM_PORTS = 5;
  localparam int CREDIT_W  = 4;

  function automatic int num_bits(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  localparam int PORT_ID_W = num_bits(NUM_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_GRANT  = 2'd2,
    ST_HOLD   = 2'd3
  } sel_state_e;

endpackage

// File: rtl/lbdr_output_port_selector_port_credit_max_select.sv
// rtl/lbdr_output_port_selector_port_credit_max_select.sv - combinational pick:
// local first, then most credits, ties broken by scanning upward from rr.
module port_credit_max_select
  import lbdr_output_port_selector_pkg::*;
#(
  parameter int NumberOfPorts      = NUM_PORTS,
  parameter int NumberOfPortsWidth = num_bits(NUM_PORTS),
  parameter int CreditWidth        = CREDIT_W
) (
  input  logic [NumberOfPorts-1:0]             mask,
  input  logic [NumberOfPorts*CreditWidth-1:0] credits,
  input  logic [NumberOfPortsWidth-1:0]        rr,
  output logic [NumberOfPorts-1:0]             grant,
  output logic [NumberOfPortsWidth-1:0]        grant_id
);

  logic [CreditWidth-1:0] best;
  logic [CreditWidth-1:0] cred;
  logic                   found;
  int                     idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    best     = '0;
    cred     = '0;
    found    = 1'b0;
    idx      = 0;
    if (mask[PORT_L]) begin
      grant[PORT_L] = 1'b1;
      grant_id      = NumberOfPortsWidth'(PORT_L);
    end else begin
      // Strict '>' keeps the earliest candidate in rr scan order on a tie.
      for (int k = 0; k < NumberOfPorts; k++) begin
        idx = int'(rr) + k;
        if (idx >= NumberOfPorts) idx = idx - NumberOfPorts;
        cred = credits[idx*CreditWidth +: CreditWidth];
        if (mask[idx] && (!found || cred > best)) begin
          found      = 1'b1;
          best       = cred;
          grant      = '0;
          grant[idx] = 1'b1;
          grant_id   = NumberOfPortsWidth'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/lbdr_output_port_selector.sv
// rtl/lbdr_output_port_selector.sv - latches the LBDR candidate mask, selects one
// output port and holds it toward VA / crossbar until the tail flit leaves.
module lbdr_output_port_selector
  import lbdr_output_port_selector_pkg::*;
#(
  parameter int NumberOfPorts      = NUM_PORTS,
  parameter int NumberOfPortsWidth = num_bits(NUM_PORTS),
  parameter int CreditWidth        = CREDIT_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumberOfPorts-1:0]             valid_ports_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [NumberOfPorts*CreditWidth-1:0] port_credits_i,
  output logic                                 sel_valid_o,
  input  logic                                 sel_ready_i,
  output logic [NumberOfPorts-1:0]             sel_port_o,
  output logic [NumberOfPortsWidth-1:0]        sel_port_id_o,
  input  logic                                 tail_done_i,
  output logic                                 route_error_o,
  output logic                                 busy_o
);

  sel_state_e                    state_q, state_d;
  logic [NumberOfPorts-1:0]      mask_q;
  logic [NumberOfPortsWidth-1:0] rr_q;
  logic [NumberOfPorts-1:0]      sel_port_q;
  logic [NumberOfPortsWidth-1:0] sel_id_q;
  logic [NumberOfPorts-1:0]      grant;
  logic [NumberOfPortsWidth-1:0] grant_id;
  logic                          release_sel;

  port_credit_max_select #(
    .NumberOfPorts     (NumberOfPorts),
    .NumberOfPortsWidth(NumberOfPortsWidth),
    .CreditWidth       (CreditWidth)
  ) u_pick (
    .mask    (mask_q),
    .credits (port_credits_i),
    .rr      (rr_q),
    .grant   (grant),
    .grant_id(grant_id)
  );

  always_comb begin
    state_d     = state_q;
    release_sel = 1'b0;
    case (state_q)
      ST_IDLE:   if (req_valid_i) state_d = ST_SELECT;
      ST_SELECT: state_d = (mask_q == '0) ? ST_IDLE : ST_GRANT;
      ST_GRANT: begin
        if (sel_ready_i) begin
          state_d     = tail_done_i ? ST_IDLE : ST_HOLD;
          release_sel = tail_done_i;
        end
      end
      ST_HOLD: begin
        if (tail_done_i) begin
          state_d     = ST_IDLE;
          release_sel = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      rr_q       <= '0;
      sel_port_q <= '0;
      sel_id_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid_i) mask_q <= valid_ports_i;
      if (state_q == ST_SELECT && mask_q != '0) begin
        sel_port_q <= grant;
        sel_id_q   <= grant_id;
        // Local ejection does not compete for mesh links, so it leaves rr alone.
        if (!mask_q[PORT_L])
          rr_q <= (int'(grant_id) == NumberOfPorts - 1) ? '0 : grant_id + 1'b1;
      end
      if (release_sel) begin
        sel_port_q <= '0;
        sel_id_q   <= '0;
      end
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign sel_valid_o   = (state_q == ST_GRANT);
  assign route_error_o = (state_q == ST_SELECT) && (mask_q == '0);
  assign sel_port_o    = sel_port_q;
  assign sel_port_id_o = sel_id_q;

endmodule
